// File: rtl/ai_core_dispatch_pkg.sv
// Shared definitions for the core dispatch path: tag field layout, core
// count, core IDs (same encoding the result collector writes) and the
// dispatcher state encoding.
package ai_core_dispatch_pkg;

  localparam int TAG_LO    = 28;
  localparam int TAG_W     = 2;
  localparam int NUM_CORES = 4;

  // Core IDs 00/01/10/11 address cores 1..4.
  localparam logic [TAG_W-1:0] CORE_ID_0 = 2'b00;
  localparam logic [TAG_W-1:0] CORE_ID_1 = 2'b01;
  localparam logic [TAG_W-1:0] CORE_ID_2 = 2'b10;
  localparam logic [TAG_W-1:0] CORE_ID_3 = 2'b11;

  // IDLE: nothing in flight; FLOW: a read was issued last cycle;
  // STALL: a word is parked in the hold register.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLOW  = 2'd1,
    ST_STALL = 2'd2
  } disp_state_e;

  // Tag to one-hot core write strobe.
  function automatic logic [NUM_CORES-1:0] core_sel(input logic [TAG_W-1:0] t);
    logic [NUM_CORES-1:0] r;
    r = '0;
    case (t)
      CORE_ID_0: r = 4'b0001;
      CORE_ID_1: r = 4'b0010;
      CORE_ID_2: r = 4'b0100;
      CORE_ID_3: r = 4'b1000;
      default:   r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ai_core_dispatch_cnt.sv
// Per-core dispatch counter. Wraps naturally at 2^CNT_W. A clear that
// coincides with a write leaves the count at 1 so that write is not lost.
module ai_dispatch_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // Count writes to this core; clear on init.
  always_ff @(posedge clk) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= {{(CNT_W-1){1'b0}}, inc};
    else if (inc) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/ai_core_dispatch.sv
// Tagged word dispatcher: pulls words from the upstream FIFO, clears the
// core tag and writes each word to the core named by its tag. Head-of-line
// blocking keeps the stream strictly in order under per-core backpressure.
module ai_core_dispatch
  import ai_core_dispatch_pkg::*;
#(
  parameter int W      = 32,
  parameter int TAG_LO = ai_core_dispatch_pkg::TAG_LO,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init,
  input  logic [W-1:0]         in_out,
  input  logic                 in_empty,
  output logic                 in_read,
  output logic [W-1:0]         core_data,
  output logic [NUM_CORES-1:0] core_wr,
  input  logic [NUM_CORES-1:0] core_full,
  output logic [CNT_W-1:0]     cnt0,
  output logic [CNT_W-1:0]     cnt1,
  output logic [CNT_W-1:0]     cnt2,
  output logic [CNT_W-1:0]     cnt3,
  output logic                 busy
);

  disp_state_e state_q, state_d;
  logic [W-1:0]         hold_q, cur, word_clr;
  logic                 pend, hold, avail, fwd;
  logic [TAG_W-1:0]     tag;
  logic [NUM_CORES-1:0][CNT_W-1:0] cnt;

  assign pend  = (state_q == ST_FLOW);
  assign hold  = (state_q == ST_STALL);
  assign busy  = pend | hold;
  // Fresh read data wins; otherwise replay the parked word.
  assign cur   = pend ? in_out : hold_q;
  assign tag   = cur[TAG_LO +: TAG_W];
  // init drops a parked word, but a word arriving from a read still goes.
  assign avail = pend | (hold & ~init);
  assign fwd   = avail & ~core_full[tag];

  // Strip the routing tag before the word reaches the cores.
  always_comb begin
    word_clr                   = cur;
    word_clr[TAG_LO +: TAG_W]  = '0;
  end

  // Next state, read strobe and core write; data is zero when not writing.
  always_comb begin
    state_d   = ST_IDLE;
    core_wr   = '0;
    core_data = '0;
    if (fwd) begin
      core_wr   = core_sel(tag);
      core_data = word_clr;
    end
    in_read = ~rst & ~init & ~in_empty & (~avail | fwd);
    if (in_read)            state_d = ST_FLOW;
    else if (avail & ~fwd)  state_d = ST_STALL;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Park a freshly read word whose target core is full.
  always_ff @(posedge clk) begin
    if (rst)              hold_q <= '0;
    else if (pend & ~fwd) hold_q <= in_out;
  end

  for (genvar k = 0; k < NUM_CORES; k++) begin : g_cnt
    ai_dispatch_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (init),
      .inc (core_wr[k]),
      .cnt (cnt[k])
    );
  end

  assign cnt0 = cnt[0];
  assign cnt1 = cnt[1];
  assign cnt2 = cnt[2];
  assign cnt3 = cnt[3];

endmodule

// File: doc/ai_core_dispatch.md
# ai_core_dispatch

Distributes a tagged 32-bit word stream from one upstream FIFO to four per-core FIFOs and performs the inverse of the core result collector. Each word carries its destination core index in bits [29:28], the same field the collector writes on the return path. The block clears the tag field and writes the word into the selected core's FIFO. It sits between the command/feature FIFO and the four comparer cores, and it honours per-core backpressure without losing or reordering words.

## Interface
- `W`, 32: word width.
- `TAG_LO`, 28: LSB of the 2-bit core tag field (tag = `[TAG_LO+1:TAG_LO]`).
- `CNT_W`, 16: width of the per-core dispatch counters.

- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `init`  in  1: single-cycle pulse that clears counters and any held word.
- `in_out`  in  W: upstream FIFO read data, valid the cycle after `in_read`.
- `in_empty`  in  1: upstream FIFO empty.
- `in_read`  out  1: upstream FIFO read strobe.
- `core_data`  out  W: word to the cores, shared by all four, tag field forced to 2'b00.
- `core_wr`  out  4: one-hot write strobe; bit k targets core k.
- `core_full`  in  4: per-core FIFO full.
- `cnt0..cnt3`  out  CNT_W each: words dispatched to each core.
- `busy`  out  1: a word is in flight or held.

## Operation
- Two registers form the datapath: `pend` (a read was issued last cycle) and `hold` (a valid word is latched in `hold_q` and waiting for its target).
- Current word source: `in_out` when `pend` is set, otherwise `hold_q`. Tag `t` is taken from the current word.
- Forward condition: a word is available and `~core_full[t]`. On forward:
  - `core_wr[t]=1`;
  - `core_data` = word with `[TAG_LO+1:TAG_LO]` cleared;
  - `cnt[t]` increments, wrapping at 2^CNT_W;
  - `hold` clears.
- Stall: a word is available but `core_full[t]` is set. The word is latched into `hold_q` if it came from `pend`, `hold` is set, and no read is issued. Blocking is head-of-line: words for other cores wait too, so order is strictly preserved.
- Read issue: `in_read = ~in_empty & (no word available | word forwarding this cycle)`. `pend` next = `in_read`.
- States are derived from the registers: IDLE (`pend=0`, `hold=0`), FLOW (`pend=1`), STALL (`hold=1`). `pend` and `hold` are never both 1.
- `init`:
  - clears all counters and drops a held word, so `hold` goes to 0;
  - a word arriving from `pend` in the same cycle is still processed normally;
  - no `in_read` is issued during the `init` cycle.
- `core_data` is 0 whenever `core_wr` is 0.
- `busy = pend | hold`.

## Timing
- Reset values: `in_read=0`, `core_wr=0`, `core_data=0`, `cnt0..3=0`, `busy=0`, `pend=0`, `hold=0`.
- Latency:
  - `in_read` at cycle N gives the core write at N+1 when the target is not full. The write is combinational from `in_out` and `core_full`.
  - A held word is written in the first cycle its `core_full` bit is low.
- Throughput: 1 word/cycle sustained with no backpressure.
- `core_full` is sampled in the same cycle as `core_wr`. The core FIFOs must not assert full later than the write that fills them.
- Reset mid-operation drops `pend` and `hold`. The upstream word already read is lost, which is acceptable because upstream is reset too.

## Structure
- The shared AI package provides:
  - `TAG_LO` and tag width 2;
  - core count 4;
  - core ID constants 0..3, matching the collector's encoding 00/01/10/11 for cores 1..4.
- No sub-module is required. The per-core counter may optionally be a small `ai_dispatch_cnt` sub-module, instantiated 4 times.

## Test plan
- Stream of words with tags 0,1,2,3,0, all `core_full=0` → `in_read` high 5 consecutive cycles, `core_wr` = 0001, 0010, 0100, 1000, 0001 on cycles 1..5; `core_data[29:28]=0`; `cnt0=2`, `cnt1..3=1`.
- Word `0x3ABCDEF0` (tag 3) with `core_full[3]=1` for 4 cycles → `busy=1`, no `in_read`, and `core_wr=1000` with `core_data=0x0ABCDEF0` in the cycle full drops.
- Head-of-line: tag-2 word stalled, next queued word tag 0 with core 0 free → tag-0 word is not read until the tag-2 word is written.
- `in_empty` toggling every cycle → no reads while empty, no duplicate or missing writes, and the counter total equals the number of words pushed.
- Pulse `init` while a word is held → `hold` cleared, all counters 0, no write of the dropped word.
- `cnt1` preloaded by 2^16−1 dispatches, then one more tag-1 word → `cnt1` wraps to 0.
